// File: rtl/alu_result_serializer.sv
// ALU output stage: latches one result or error code per valid/ready handshake
// and shifts a framed, CRC/parity-protected bit stream out on sout, MSB first.
module alu_result_serializer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  output logic        ready,
  input  logic        is_err,
  input  logic [31:0] c,
  input  logic [3:0]  flags,
  input  logic [2:0]  err_flags,
  output logic        sout,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t        state, state_n;
  logic [54:0]   sreg, sreg_n;
  logic [5:0]    bits_left, bits_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          sout_n, done_n;

  logic          last_bit, accept, parity;
  logic [2:0]    crc;
  logic [54:0]   frame;

  // Serial LFSR form of M(x)*x^3 mod (x^3+x+1), MSB of the message first.
  function automatic logic [2:0] crc3(input logic [36:0] m);
    logic [2:0] r;
    logic       fb;
    r = '0;
    for (int i = 36; i >= 0; i--) begin
      fb = m[i] ^ r[2];
      r  = {r[1], r[0] ^ fb, fb};
    end
    return r;
  endfunction

  assign crc    = crc3({c, 1'b0, flags});
  assign parity = ^{1'b1, err_flags, err_flags};

  // Error frames sit left-aligned so both frame kinds leave from bit 54.
  assign frame = is_err
    ? {2'b01, 1'b1, err_flags, err_flags, parity, 1'b1, 44'b0}
    : {2'b00, c[31:24], 1'b1,
       2'b00, c[23:16], 1'b1,
       2'b00, c[15:8],  1'b1,
       2'b00, c[7:0],   1'b1,
       2'b01, 1'b0, flags, crc, 1'b1};

  // The stop-bit cycle also accepts when no gap follows, so frames can abut.
  assign last_bit = (state == SEND) && (bits_left == 6'd0);
  assign ready    = (state == IDLE) || (last_bit && (GAP_CYCLES == 0));
  assign accept   = valid && ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_n = state;
    sreg_n  = sreg;
    bits_n  = bits_left;
    gap_n   = gap_cnt;
    sout_n  = 1'b1;
    done_n  = 1'b0;
    case (state)
      IDLE: ;
      SEND: begin
        if (bits_left != 6'd0) begin
          sout_n = sreg[54];
          sreg_n = {sreg[53:0], 1'b0};
          bits_n = bits_left - 6'd1;
        end else if (GAP_CYCLES > 0) begin
          state_n = GAP;
          gap_n   = GW'(GAP_CYCLES - 1);
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          gap_n = gap_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (accept) begin
      state_n = SEND;
      sout_n  = frame[54];
      sreg_n  = {frame[53:0], 1'b0};
      bits_n  = is_err ? 6'd10 : 6'd54;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      bits_left <= '0;
      gap_cnt   <= '0;
      sout      <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      bits_left <= bits_n;
      gap_cnt   <= gap_n;
      sout      <= sout_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: frame bits, CRC/parity, handshake
// timing, back-to-back frames, mid-frame reset and the inter-frame gap.
module tb_alu_result_serializer;

  logic        clk = 1'b0;
  logic        rst, valid, valid_g, is_err;
  logic [31:0] c;
  logic [3:0]  flags;
  logic [2:0]  err_flags;
  logic        ready, sout, done;
  logic        ready_g, sout_g, done_g;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_result_serializer #(.GAP_CYCLES(0)) u_dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .is_err(is_err),
    .c(c), .flags(flags), .err_flags(err_flags), .sout(sout), .done(done)
  );

  alu_result_serializer #(.GAP_CYCLES(2)) u_dut_gap (
    .clk(clk), .rst(rst), .valid(valid_g), .ready(ready_g), .is_err(is_err),
    .c(c), .flags(flags), .err_flags(err_flags), .sout(sout_g), .done(done_g)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame layout with a hand-computed CRC supplied by the caller.
  function automatic logic [54:0] data_frame(input logic [31:0] cv, input logic [3:0] fv,
                                             input logic [2:0] crcv);
    return {2'b00, cv[31:24], 1'b1, 2'b00, cv[23:16], 1'b1,
            2'b00, cv[15:8],  1'b1, 2'b00, cv[7:0],   1'b1,
            3'b010, fv, crcv, 1'b1};
  endfunction

  // Drive one result, accept on the next rising edge, return at E0+1.
  task automatic start_frame(input logic e, input logic [31:0] cv, input logic [3:0] fv,
                             input logic [2:0] ev, input bit hold);
    @(negedge clk);
    is_err = e; c = cv; flags = fv; err_flags = ev; valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) valid = 1'b0;
    is_err = ~e; c = ~cv; flags = ~fv; err_flags = ~ev;
  endtask

  // Checks bits 0..len-1 starting at E0+1; returns at E(len)+1.
  task automatic check_bits(input logic [54:0] exp, input int len, input string tag);
    for (int k = 0; k < len; k++) begin
      check($sformatf("%s_bit%0d", tag, k), sout, exp[54-k]);
      if (k == len / 2) begin
        check({tag, "_ready_mid"}, ready, 1'b0);
        check({tag, "_done_mid"}, done, 1'b0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_end(input string tag);
    check({tag, "_ready_end"}, ready, 1'b1);
    check({tag, "_done_end"}, done, 1'b1);
    check({tag, "_sout_end"}, sout, 1'b1);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, done, 1'b0);
  endtask

  initial begin
    logic [54:0] exp_a, exp_b, exp_e;
    rst = 1'b1; valid = 1'b0; valid_g = 1'b0;
    is_err = 1'b0; c = '0; flags = '0; err_flags = '0;

    // Reset state and idle line
    repeat (2) @(posedge clk);
    #1;
    check("rst_sout", sout, 1'b1);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle_sout_%0d", i), sout, 1'b1);
    end

    // All-zero data frame, CRC 000
    start_frame(1'b0, 32'h0, 4'b0000, 3'b000, 1'b0);
    check_bits(data_frame(32'h0, 4'b0000, 3'b000), 55, "zero");
    check_end("zero");

    // c=1: last data byte 00000001, CRC x^8 mod G = 010
    start_frame(1'b0, 32'h1, 4'b0000, 3'b000, 1'b0);
    check_bits({2'b00, 8'h00, 1'b1, 2'b00, 8'h00, 1'b1, 2'b00, 8'h00, 1'b1,
                2'b00, 8'h01, 1'b1, 3'b010, 4'b0000, 3'b010, 1'b1}, 55, "crc1");
    check_end("crc1");

    // Byte order and flags: x^39+x^6+x^3 reduces to 0
    start_frame(1'b0, 32'h8000_0000, 4'b1001, 3'b000, 1'b0);
    check_bits({2'b00, 8'h80, 1'b1, 2'b00, 8'h00, 1'b1, 2'b00, 8'h00, 1'b1,
                2'b00, 8'h00, 1'b1, 3'b010, 4'b1001, 3'b000, 1'b1}, 55, "order");
    check_end("order");

    // Flags only: (x^2+x)*x^3 mod G = 1 -> 001
    start_frame(1'b0, 32'h0, 4'b0110, 3'b000, 1'b0);
    check_bits(data_frame(32'h0, 4'b0110, 3'b001), 55, "flags");
    check_end("flags");

    // Error frame 0,1,1,100,100,1,1
    exp_e = {11'b011_100_100_11, 44'b0};
    start_frame(1'b1, 32'hFFFF_FFFF, 4'b1111, 3'b100, 1'b0);
    check_bits(exp_e, 11, "err");
    check_end("err");

    // Back-to-back: A (c=1, crc 010) then B (flags 0001, crc 011) with valid held
    exp_a = data_frame(32'h1, 4'b0000, 3'b010);
    exp_b = data_frame(32'h0, 4'b0001, 3'b011);
    start_frame(1'b0, 32'h1, 4'b0000, 3'b000, 1'b1);
    is_err = 1'b0; c = 32'h0; flags = 4'b0001; err_flags = 3'b000;
    check_bits(exp_a, 55, "b2b_a");
    check("b2b_done_a", done, 1'b1);
    check("b2b_ready_a", ready, 1'b0);
    valid = 1'b0;
    check_bits(exp_b, 55, "b2b_b");
    check_end("b2b_b");

    // Reset pulsed while bit 20 is on the line
    start_frame(1'b0, 32'h1, 4'b0110, 3'b000, 1'b0);
    check_bits(exp_a, 20, "rstmid");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_sout", sout, 1'b1);
    check("rstmid_ready", ready, 1'b1);
    check("rstmid_done", done, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid_quiet_done_%0d", i), done, 1'b0);
      check($sformatf("rstmid_quiet_sout_%0d", i), sout, 1'b1);
    end
    // Clean accept afterwards: c=1, flags=0110 -> crc 011
    start_frame(1'b0, 32'h1, 4'b0110, 3'b000, 1'b0);
    check_bits(data_frame(32'h1, 4'b0110, 3'b011), 55, "after_rst");
    check_end("after_rst");

    // valid together with rst: nothing accepted
    @(negedge clk);
    rst = 1'b1; valid = 1'b1; is_err = 1'b0; c = 32'h0; flags = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    check("vrst_sout", sout, 1'b1);
    check("vrst_ready", ready, 1'b1);
    @(posedge clk); #1;
    check("vrst_sout_next", sout, 1'b1);
    check("vrst_ready_next", ready, 1'b1);

    // GAP_CYCLES=2 instance: error frame, ready/done at E13
    @(negedge clk);
    is_err = 1'b1; err_flags = 3'b100; valid_g = 1'b1;
    @(posedge clk); #1;
    valid_g = 1'b0; err_flags = 3'b011;
    for (int k = 0; k < 11; k++) begin
      check($sformatf("gap_bit%0d", k), sout_g, exp_e[54-k]);
      @(posedge clk); #1;
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("gap_sout_%0d", g), sout_g, 1'b1);
      check($sformatf("gap_ready_%0d", g), ready_g, 1'b0);
      check($sformatf("gap_done_%0d", g), done_g, 1'b0);
      @(posedge clk); #1;
    end
    check("gap_ready_end", ready_g, 1'b1);
    check("gap_done_end", done_g, 1'b1);
    check("gap_sout_end", sout_g, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
